// File: rtl/nega_serial_acc_pkg.sv
// Shared types for the bit-serial negabinary accumulator: FSM encoding and
// the digit-counter width helper.
package nega_serial_acc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter must stay at least one bit wide even for a single-digit accumulator.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nega_serial_acc_digit_add.sv
// One negabinary digit adder with two-rail carry: t = a + b + cp - cn,
// s = t mod 2, carry value (t - s) / -2 split onto cp (+1) and cn (-1).
module nega_digit_add (
  input  logic a,
  input  logic b,
  input  logic cn,
  input  logic cp,
  output logic s,
  output logic cn_out,
  output logic cp_out
);

  logic signed [2:0] t;

  always_comb begin
    t = $signed({2'b00, a}) + $signed({2'b00, b})
      + $signed({2'b00, cp}) - $signed({2'b00, cn});
    s      = t[0];
    cp_out = (t == -3'sd1);
    cn_out = (t > 3'sd1);
  end

endmodule

// File: rtl/nega_serial_acc.sv
// Bit-serial negabinary accumulator: one digit per clock through a single
// digit adder, with clear command, result strobe and sticky overflow.
//
// state   | meaning
// IDLE    | in_ready high, waiting for an add or clear command
// RUN     | adding one digit per cycle, acc and operand rotate right
// DONE    | out_valid high for this cycle, back to IDLE next
module nega_serial_acc
  import nega_serial_acc_pkg::*;
#(
  parameter int W     = 8,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_clr,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  output logic [ACC_W-1:0] acc,
  output logic             ovf
);

  localparam int             CW   = cnt_width(ACC_W);
  localparam logic [CW-1:0]  LAST = CW'(ACC_W - 1);

  state_t             state;
  logic [ACC_W-1:0]   op;
  logic [CW-1:0]      cnt;
  logic               cp;
  logic               cn;
  logic               s;
  logic               cp_nx;
  logic               cn_nx;

  nega_digit_add u_digit_add (
    .a      (acc[0]),
    .b      (op[0]),
    .cn     (cn),
    .cp     (cp),
    .s      (s),
    .cn_out (cn_nx),
    .cp_out (cp_nx)
  );

  assign in_ready = (state == ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      acc       <= '0;
      op        <= '0;
      cnt       <= '0;
      cp        <= 1'b0;
      cn        <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            if (in_clr) begin
              acc       <= '0;
              ovf       <= 1'b0;
              out_valid <= 1'b1;
              state     <= ST_DONE;
            end else begin
              op    <= ACC_W'(in_data);
              cnt   <= '0;
              cp    <= 1'b0;
              cn    <= 1'b0;
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          // Sum digit enters at the top; after ACC_W rotations acc is realigned.
          acc <= (acc >> 1) | (ACC_W'(s) << (ACC_W - 1));
          op  <= op >> 1;
          cp  <= cp_nx;
          cn  <= cn_nx;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            if (cp_nx || cn_nx) ovf <= 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nega_serial_acc.sv
// Scoreboard bench: integer reference model of a negabinary running sum,
// expectations queued at accept time and checked when out_valid strobes.
module tb_nega_serial_acc;

  localparam int W      = 8;
  localparam int ACC_W  = 16;
  localparam int SW     = 4;
  localparam int SACC_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_clr = 1'b0;
  logic [W-1:0]     in_data = '0;
  logic             in_ready;
  logic             out_valid;
  logic [ACC_W-1:0] acc;
  logic             ovf;

  logic              s_valid = 1'b0;
  logic              s_clr = 1'b0;
  logic [SW-1:0]     s_data = '0;
  logic              s_ready;
  logic              s_ov;
  logic [SACC_W-1:0] s_acc;
  logic              s_ovf;

  nega_serial_acc #(.W(W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_clr(in_clr), .in_data(in_data), .out_valid(out_valid), .acc(acc), .ovf(ovf)
  );

  nega_serial_acc #(.W(SW), .ACC_W(SACC_W)) dut_small (
    .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(s_ready),
    .in_clr(s_clr), .in_data(s_data), .out_valid(s_ov), .acc(s_acc), .ovf(s_ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nb_dec(input logic [31:0] d, input int n);
    int v, w;
    v = 0; w = 1;
    for (int i = 0; i < n; i++) begin
      if (d[i]) v += w;
      w *= -2;
    end
    return v;
  endfunction

  function automatic logic [31:0] nb_enc(input int v);
    logic [31:0] d;
    int n, r;
    d = '0; n = v;
    for (int i = 0; i < 32; i++) begin
      r = n & 1;
      d[i] = r[0];
      n = (n - r) / (-2);
    end
    return d;
  endfunction

  int m_val = 0;
  bit m_ovf = 1'b0;

  typedef struct {
    logic [ACC_W-1:0] acc;
    bit               ovf;
    int               acc_edge;
    int               lat;
  } exp_t;
  exp_t q[$];

  // One negedge step; while busy, in_valid carries junk that must be ignored.
  task automatic tick();
    @(negedge clk);
    if (in_ready) begin
      in_valid = 1'b0;
    end else begin
      in_valid = 1'($urandom_range(0, 1));
      in_clr   = 1'($urandom_range(0, 1));
      in_data  = W'($urandom);
    end
  endtask

  task automatic issue(input bit clr, input logic [W-1:0] data);
    int t;
    exp_t e;
    logic [31:0] full;
    t = 0;
    tick();
    while (!in_ready && t < 200) begin
      tick();
      t++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 0, 1);
      return;
    end
    in_valid = 1'b1;
    in_clr   = clr;
    in_data  = data;
    if (clr) begin
      m_val = 0;
      m_ovf = 1'b0;
    end else begin
      full = nb_enc(m_val + nb_dec(32'(data), W));
      if (full[31:ACC_W] != '0) m_ovf = 1'b1;
      m_val = nb_dec(32'(full[ACC_W-1:0]), ACC_W);
    end
    full       = nb_enc(m_val);
    e.acc      = full[ACC_W-1:0];
    e.ovf      = m_ovf;
    e.acc_edge = cyc + 1;
    // Clear lands in DONE at the accept edge; an add after ACC_W RUN edges.
    e.lat      = clr ? 0 : ACC_W;
    q.push_back(e);
    tick();
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() > 0 && t < 100) begin
      tick();
      t++;
    end
    if (q.size() > 0) chk("drain_timeout", q.size(), 0);
    tick();
    tick();
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    bit prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (prev) chk("ready_after_strobe", int'(in_ready), 1);
        if (out_valid) begin
          chk("ready_low_in_done", int'(in_ready), 0);
          if (q.size() == 0) begin
            chk("unexpected_out_valid", 1, 0);
          end else begin
            e = q.pop_front();
            chk("acc", int'(acc), int'(e.acc));
            chk("ovf", int'(ovf), int'(e.ovf));
            chk("strobe_latency", cyc - e.acc_edge, e.lat);
          end
        end
        prev = out_valid;
      end else begin
        prev = 1'b0;
      end
    end
  end

  // ---------------- small instance, directed ----------------
  task automatic s_op(input bit clr, input logic [SW-1:0] d,
                      input logic [SACC_W-1:0] ea, input bit eo, input string nm);
    int t;
    t = 0;
    @(negedge clk);
    while (!s_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    s_valid = 1'b1;
    s_clr   = clr;
    s_data  = d;
    @(negedge clk);
    s_valid = 1'b0;
    t = 0;
    while (!s_ov && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (s_ov) begin
      chk({nm, "_acc"}, int'(s_acc), int'(ea));
      chk({nm, "_ovf"}, int'(s_ovf), int'(eo));
    end else begin
      chk({nm, "_strobe_timeout"}, 0, 1);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_acc", int'(acc), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 4-digit accumulator: 5 + 5 = 10 truncates to 1110 (-6) with overflow
    s_op(1'b1, 4'b0000, 4'b0000, 1'b0, "s_clr0");
    s_op(1'b0, 4'b0101, 4'b0101, 1'b0, "s_add5");
    s_op(1'b0, 4'b0101, 4'b1110, 1'b1, "s_ovf");
    s_op(1'b0, 4'b0000, 4'b1110, 1'b1, "s_sticky");
    s_op(1'b1, 4'b0000, 4'b0000, 1'b0, "s_clr1");

    issue(1'b0, 8'h01);
    issue(1'b0, 8'h01);
    drain();
    chk("one_plus_one", int'(acc), 16'h0006);

    issue(1'b1, 8'h00);
    issue(1'b0, 8'h01);
    issue(1'b0, 8'h03);
    drain();
    chk("one_minus_one", int'(acc), 16'h0000);

    for (int i = 0; i < 40; i++) begin
      issue(($urandom_range(0, 9) == 0), W'($urandom));
      repeat ($urandom_range(0, 3)) tick();
    end
    drain();

    // Drive the positive maximum (0x5555) past its limit.
    issue(1'b1, 8'h00);
    for (int i = 0; i < 260; i++) issue(1'b0, 8'h55);
    issue(1'b0, W'($urandom));
    drain();
    chk("ovf_sticky", int'(ovf), 1);
    issue(1'b1, 8'h00);
    drain();
    chk("clr_after_ovf_acc", int'(acc), 0);
    chk("clr_after_ovf_ovf", int'(ovf), 0);

    issue(1'b0, 8'h11);
    drain();
    issue(1'b0, 8'h2d);
    repeat (6) tick();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    q.delete();
    m_val = 0;
    m_ovf = 1'b0;
    #1;
    chk("midrun_rst_acc", int'(acc), 0);
    chk("midrun_rst_ovf", int'(ovf), 0);
    chk("midrun_rst_out_valid", int'(out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", int'(in_ready), 1);
    chk("post_rst_acc", int'(acc), 0);
    repeat (ACC_W + 4) tick();

    issue(1'b0, 8'h07);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
